ahb_lsu_manager: RTL and testbench

// AHB-Lite manager (initiator) between the CPU load/store unit and the data-side bus.

---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/lsu_load_align.sv | 25 ++
 rtl/ahb_lsu_manager.sv | 160 ++++++++++++++++
 tb/tb_ahb_lsu_manager.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and load/store manager types, used by both
// manager and subordinate sides of the data bus.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ERRQ
  } lsu_mgr_state_t;

  // A request is legal when its size is supported and naturally aligned.
  function automatic logic lsu_req_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate LSB-justified store data across every byte lane it could occupy.
  function automatic logic [31:0] lsu_lane_replicate(input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      HSIZE_BYTE: r = {4{wdata[7:0]}};
      HSIZE_HALF: r = {2{wdata[15:0]}};
      default:    r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension from a 32-bit bus word.
module lsu_load_align
  import ahb_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [15:0] lane;

  always_comb begin
    lane = 16'(rdata >> {addr_lo, 3'b000});
    data = '0;
    case (size)
      HSIZE_BYTE: data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      HSIZE_HALF: data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      HSIZE_WORD: data = rdata;
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/ahb_lsu_manager.sv
// AHB-Lite manager for the LSU: one SINGLE transfer per request, one outstanding,
// registered bus outputs, aligned/extended load return with error status.
module ahb_lsu_manager
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [2:0]            lsu_size_i,
  input  logic                  lsu_unsigned_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ready_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  resp_read,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  lsu_mgr_state_t state_q, state_d;

  logic                  accept;
  logic                  req_legal;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] load_data;

  logic [ADDR_WIDTH-1:0] haddr_d;
  logic                  hwrite_d;
  logic [2:0]            hsize_d;
  logic [1:0]            htrans_d;
  logic [DATA_WIDTH-1:0] hwdata_d;
  logic                  resp_read_d;
  logic                  rvalid_d;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;

  assign lsu_ready_o = (state_q == IDLE);
  assign accept      = lsu_req_i & lsu_ready_o;
  assign req_legal   = lsu_req_legal(lsu_size_i, lsu_addr_i[1:0]);

  // HADDR/HSIZE double as the captured request for the load return path.
  lsu_load_align u_load_align (
    .addr_lo     (HADDR[1:0]),
    .size        (HSIZE),
    .is_unsigned (uns_q),
    .rdata       (HRDATA),
    .data        (load_data)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      HADDR        <= '0;
      HWRITE       <= 1'b0;
      HSIZE        <= '0;
      HTRANS       <= HTRANS_IDLE;
      HWDATA       <= '0;
      resp_read    <= 1'b0;
      lsu_rvalid_o <= 1'b0;
      lsu_err_o    <= 1'b0;
      lsu_rdata_o  <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      HADDR        <= haddr_d;
      HWRITE       <= hwrite_d;
      HSIZE        <= hsize_d;
      HTRANS       <= htrans_d;
      HWDATA       <= hwdata_d;
      resp_read    <= resp_read_d;
      lsu_rvalid_o <= rvalid_d;
      lsu_err_o    <= err_d;
      lsu_rdata_o  <= rdata_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = req_legal ? ADDR : ERRQ;
      ADDR: if (HREADY) state_d = DATA;
      DATA: if (HREADY) state_d = IDLE;
      ERRQ: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus and LSU outputs.
  always_comb begin
    haddr_d     = HADDR;
    hwrite_d    = HWRITE;
    hsize_d     = HSIZE;
    htrans_d    = HTRANS;
    hwdata_d    = HWDATA;
    resp_read_d = resp_read;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = lsu_rdata_o;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_legal) begin
            haddr_d     = lsu_addr_i;
            hwrite_d    = lsu_we_i;
            hsize_d     = lsu_size_i;
            htrans_d    = HTRANS_NONSEQ;
            resp_read_d = ~lsu_we_i;
            uns_d       = lsu_unsigned_i;
            wdata_d     = lsu_wdata_i;
          end else begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end
        end
      end
      ADDR: begin
        if (HREADY) begin
          htrans_d    = HTRANS_IDLE;
          resp_read_d = 1'b0;
          hwdata_d    = lsu_lane_replicate(HSIZE, wdata_q);
        end
      end
      DATA: begin
        if (HREADY) begin
          rvalid_d = 1'b1;
          err_d    = HRESP;
          rdata_d  = HWRITE ? '0 : load_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lsu_manager.sv
// Directed and randomized bench for ahb_lsu_manager against a transaction-level model.
module tb_ahb_lsu_manager;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
  logic [11:0] lsu_addr_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_ready_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic [11:0] HADDR;
  logic        HWRITE, HMASTLOCK, resp_read;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  ahb_lsu_manager #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ready_o(lsu_ready_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .resp_read(resp_read),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic bit is_legal(input logic [2:0] size, input logic [11:0] addr);
    int unsigned bytes;
    if (size > 3'd2) return 1'b0;
    bytes = 1 << size;
    return (addr % bytes) == 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [11:0] addr, input logic [2:0] size,
                                           input bit uns, input logic [31:0] bus);
    int unsigned off = addr % 4;
    logic [31:0] v;
    if (size == 3'd0) begin
      v = (bus >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 3'd1) begin
      v = (bus >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = bus;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] size, input logic [31:0] w);
    if (size == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  // One complete request from accept to completion; leaves the bench in the
  // cycle where the completion pulse is visible so a following call is back-to-back.
  task automatic do_txn(input bit we, input logic [11:0] addr, input logic [2:0] size,
                        input bit uns, input logic [31:0] wdata, input int unsigned awaits,
                        input int unsigned dwaits, input bit err, input logic [31:0] bus);
    chk("ready_before_req", 32'(lsu_ready_o), 32'd1);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_addr_i = addr; lsu_size_i = size;
    lsu_unsigned_i = uns; lsu_wdata_i = wdata;
    HREADY = 1'b1; HRESP = 1'b0;
    tick();
    lsu_req_i = 1'b0;
    lsu_wdata_i = $urandom;
    lsu_addr_i = 12'($urandom);
    if (!is_legal(size, addr)) begin
      chk("illegal_rvalid", 32'(lsu_rvalid_o), 32'd1);
      chk("illegal_err", 32'(lsu_err_o), 32'd1);
      chk("illegal_rdata", lsu_rdata_o, 32'd0);
      chk("illegal_htrans", 32'(HTRANS), 32'd0);
      chk("illegal_ready", 32'(lsu_ready_o), 32'd0);
      tick();
      chk("illegal_rvalid_end", 32'(lsu_rvalid_o), 32'd0);
      chk("illegal_htrans_end", 32'(HTRANS), 32'd0);
      chk("illegal_ready_end", 32'(lsu_ready_o), 32'd1);
      return;
    end
    chk("addr_rvalid_low", 32'(lsu_rvalid_o), 32'd0);
    chk("addr_ready_low", 32'(lsu_ready_o), 32'd0);
    for (int i = 0; i <= int'(awaits); i++) begin
      HREADY = (i == int'(awaits));
      chk("addr_htrans", 32'(HTRANS), 32'd2);
      chk("addr_haddr", 32'(HADDR), 32'(addr));
      chk("addr_hwrite", 32'(HWRITE), 32'(we));
      chk("addr_hsize", 32'(HSIZE), 32'(size));
      chk("addr_resp_read", 32'(resp_read), 32'(!we));
      tick();
    end
    chk("data_htrans", 32'(HTRANS), 32'd0);
    chk("data_resp_read", 32'(resp_read), 32'd0);
    for (int i = 0; i <= int'(dwaits); i++) begin
      HREADY = (i == int'(dwaits));
      HRESP  = err && (i + 1 >= int'(dwaits));
      HRDATA = (i == int'(dwaits)) ? bus : $urandom;
      if (we) chk("data_hwdata", HWDATA, exp_wdata(size, wdata));
      chk("data_rvalid_low", 32'(lsu_rvalid_o), 32'd0);
      tick();
    end
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    chk("done_rvalid", 32'(lsu_rvalid_o), 32'd1);
    chk("done_err", 32'(lsu_err_o), 32'(err));
    chk("done_rdata", lsu_rdata_o, we ? 32'd0 : exp_load(addr, size, uns, bus));
    chk("done_ready", 32'(lsu_ready_o), 32'd1);
    chk("done_htrans", 32'(HTRANS), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    chk({tag, "_haddr"}, 32'(HADDR), 32'd0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
    chk({tag, "_hsize"}, 32'(HSIZE), 32'd0);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_resp_read"}, 32'(resp_read), 32'd0);
    chk({tag, "_rvalid"}, 32'(lsu_rvalid_o), 32'd0);
    chk({tag, "_err"}, 32'(lsu_err_o), 32'd0);
    chk({tag, "_rdata"}, lsu_rdata_o, 32'd0);
    chk({tag, "_ready"}, 32'(lsu_ready_o), 32'd1);
  endtask

  initial begin
    logic [2:0]  rsize;
    logic [11:0] raddr;
    bit          rwe, rerr;
    int unsigned rdw;

    HRESETn = 1'b0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_size_i = '0;
    lsu_unsigned_i = 1'b0; lsu_wdata_i = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick();
    tick();
    chk_reset_values("reset");
    chk("hburst", 32'(HBURST), 32'd0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'd0);
    HRESETn = 1'b1;
    tick();

    do_txn(1'b0, 12'h104, 3'd2, 1'b0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
    tick();
    do_txn(1'b0, 12'h103, 3'd0, 1'b0, 32'h0, 0, 2, 1'b0, 32'h8012_3456);
    do_txn(1'b1, 12'h102, 3'd1, 1'b0, 32'h0000_ABCD, 1, 2, 1'b0, 32'h0);
    do_txn(1'b0, 12'h101, 3'd2, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 12'h200, 3'd2, 1'b0, 32'h0, 0, 1, 1'b1, 32'h1234_5678);
    do_txn(1'b0, 12'h206, 3'd1, 1'b1, 32'h0, 0, 0, 1'b0, 32'h9ABC_0000);
    tick();

    // Abandon a load part-way through its data phase.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 12'h300; lsu_size_i = 3'd2;
    HREADY = 1'b1;
    tick();
    lsu_req_i = 1'b0;
    tick();
    HREADY = 1'b0;
    tick();
    #2 HRESETn = 1'b0;
    #1 chk_reset_values("midreset");
    tick();
    HREADY = 1'b1;
    HRESETn = 1'b1;
    tick();
    chk("after_reset_rvalid", 32'(lsu_rvalid_o), 32'd0);
    chk("after_reset_htrans", 32'(HTRANS), 32'd0);
    do_txn(1'b0, 12'h302, 3'd0, 1'b1, 32'h0, 0, 0, 1'b0, 32'h00AA_0000);

    for (int n = 0; n < 150; n++) begin
      rsize = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      raddr = 12'($urandom);
      if ($urandom_range(0, 3) != 0) raddr = raddr & ~12'((1 << rsize) - 1);
      rwe  = $urandom_range(0, 1);
      rerr = ($urandom_range(0, 7) == 0);
      rdw  = $urandom_range(0, 3);
      if (rerr && rdw == 0) rdw = 1;
      do_txn(rwe, raddr, rsize, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 2), rdw, rerr, $urandom);
      for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
        tick();
        chk("idle_htrans", 32'(HTRANS), 32'd0);
        chk("idle_rvalid", 32'(lsu_rvalid_o), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
